// File: rtl/bist_seq_engine.sv
// bist_seq_engine: BIST vector sequencer. Vectors {stim, exp, mask, last} are
// loaded through a valid/ready port. They are then replayed to the DUT
// (loop_cnt+1 passes), and each DUT response is compared against its masked
// expect value RESP_LAT cycles after the vector was issued.
//
// Ports
//   clk, TLR_n                 clock, synchronous active-low reset
//   load_clear/valid/ready/data vector load interface ({stim, exp, mask, last})
//   start, abort               run control pulses
//   stop_on_err, loop_cnt      run mode, sampled at start
//   bist_out, bist_out_vld     stimulus to the DUT
//   bist_in                    DUT response
//   busy, done, fail           status flags
//   vec_count, err_count       loaded vectors, saturating mismatch count
//   fail_addr, fail_data       first mismatching vector address and response
//
// state | meaning
// IDLE  | loading allowed, waiting for start
// RUN   | issuing one vector per cycle
// DRAIN | issue finished, waiting for the in-flight responses
// DONE  | run complete (errors possible when stop_on_err=0)
// FAIL  | run halted on a mismatch with stop_on_err=1
module bist_seq_engine #(
  parameter int DEPTH    = 256,
  parameter int DATA_W   = 4,
  parameter int RESP_W   = 4,
  parameter int RESP_LAT = 2,
  parameter int CNT_W    = 8,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       TLR_n,
  input  logic                       load_clear,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [DATA_W+2*RESP_W:0]   load_data,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       stop_on_err,
  input  logic [7:0]                 loop_cnt,
  output logic [DATA_W-1:0]          bist_out,
  output logic                       bist_out_vld,
  input  logic [RESP_W-1:0]          bist_in,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic [AW:0]                vec_count,
  output logic [CNT_W-1:0]           err_count,
  output logic [AW-1:0]              fail_addr,
  output logic [RESP_W-1:0]          fail_data
);

  localparam int LW = DATA_W + 2*RESP_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_FAIL} state_t;

  typedef struct packed {
    logic [RESP_W-1:0] exp;
    logic [RESP_W-1:0] mask;
    logic [AW-1:0]     pc;
    logic              vld;
  } stage_t;

  logic [LW-1:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  logic [7:0]          loops_q, loops_d;
  logic                stop_q, stop_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [AW-1:0]       faddr_q, faddr_d;
  logic [RESP_W-1:0]   fdata_q, fdata_d;
  logic                seen_q, seen_d;
  stage_t              pipe_q [RESP_LAT];
  stage_t              pipe_d [RESP_LAT];

  logic [RESP_W-1:0]   cur_exp, cur_mask;
  logic                cur_last, issue_end, start_ok, load_fire;
  logic                mism, pend, flush;
  stage_t              tail;

  assign cur_exp   = mem[pc_q][2*RESP_W -: RESP_W];
  assign cur_mask  = mem[pc_q][RESP_W -: RESP_W];
  assign cur_last  = mem[pc_q][0];
  assign issue_end = ({1'b0, pc_q} == cnt_q - 1'b1) || cur_last;
  assign start_ok  = start && (cnt_q != '0) &&
                     (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  assign load_ready = (state_q == S_IDLE) && !start && (cnt_q < (AW+1)'(DEPTH));
  assign load_fire  = load_valid && load_ready && !load_clear;

  // Oldest pipe stage lines up with the response on bist_in this cycle.
  assign tail = pipe_q[RESP_LAT-1];
  assign mism = (state_q == S_RUN || state_q == S_DRAIN) && tail.vld &&
                (|((bist_in ^ tail.exp) & tail.mask));

  // Responses still outstanding after this cycle's compare.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < RESP_LAT-1; i++) pend = pend | pipe_q[i].vld;
  end

  always_ff @(posedge clk) begin
    if (load_fire) mem[cnt_q[AW-1:0]] <= load_data;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    loops_d = loops_q;
    stop_d  = stop_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    seen_d  = seen_q;
    flush   = 1'b0;

    pipe_d[0] = '{exp: cur_exp, mask: cur_mask, pc: pc_q, vld: vld_q && (state_q == S_RUN)};
    for (int i = 1; i < RESP_LAT; i++) pipe_d[i] = pipe_q[i-1];

    if (load_fire) cnt_d = cnt_q + 1'b1;

    if (mism) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (!seen_q) begin
        seen_d  = 1'b1;
        faddr_d = tail.pc;
        fdata_d = bist_in;
      end
    end

    case (state_q)
      S_RUN: begin
        if (issue_end) begin
          if (loops_q != 8'd0) begin
            pc_d    = '0;
            loops_d = loops_q - 8'd1;
          end else begin
            state_d = S_DRAIN;
            vld_d   = 1'b0;
          end
        end else begin
          pc_d = pc_q + 1'b1;
        end
        if (mism && stop_q) begin
          state_d = S_FAIL;
          vld_d   = 1'b0;
          flush   = 1'b1;
        end
      end
      S_DRAIN: begin
        vld_d = 1'b0;
        if (mism && stop_q) begin
          state_d = S_FAIL;
          flush   = 1'b1;
        end else if (!pend) begin
          state_d = S_DONE;
        end
      end
      default: begin
        // IDLE, DONE, FAIL
        if (start_ok) begin
          state_d = S_RUN;
          pc_d    = '0;
          loops_d = loop_cnt;
          stop_d  = stop_on_err;
          vld_d   = 1'b1;
          err_d   = '0;
          faddr_d = '0;
          fdata_d = '0;
          seen_d  = 1'b0;
          flush   = 1'b1;
        end else if (load_clear) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      vld_d   = 1'b0;
      flush   = 1'b1;
    end

    if (flush) begin
      for (int i = 0; i < RESP_LAT; i++) pipe_d[i].vld = 1'b0;
    end

    out_d = vld_d ? mem[pc_d][LW-1 -: DATA_W] : '0;
  end

  always_ff @(posedge clk) begin
    if (!TLR_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      loops_q <= '0;
      stop_q  <= 1'b0;
      vld_q   <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
      seen_q  <= 1'b0;
      for (int i = 0; i < RESP_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      loops_q <= loops_d;
      stop_q  <= stop_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      seen_q  <= seen_d;
      pipe_q  <= pipe_d;
    end
  end

  assign bist_out     = out_q;
  assign bist_out_vld = vld_q;
  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE) || (state_q == S_FAIL);
  assign fail         = (state_q == S_FAIL) || ((state_q == S_DONE) && (err_q != '0));
  assign vec_count    = cnt_q;
  assign err_count    = err_q;
  assign fail_addr    = faddr_q;
  assign fail_data    = fdata_q;

endmodule

// File: tb/tb_bist_seq_engine.sv
// Testbench for bist_seq_engine. The DUT model echoes each vector's expected
// response RESP_LAT cycles after issue, optionally corrupted per stimulus
// value. Issued stimuli are checked against a scoreboard queue.
module tb_bist_seq_engine;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        TLR_n = 1'b0;
  logic        load_clear = 1'b0, load_valid = 1'b0, load_ready;
  logic [12:0] load_data = '0;
  logic        start = 1'b0, abort = 1'b0, stop_on_err = 1'b0;
  logic [7:0]  loop_cnt = '0;
  logic [3:0]  bist_out;
  logic        bist_out_vld;
  logic [3:0]  bist_in = '0;
  logic        busy, done, fail;
  logic [AW:0] vec_count;
  logic [7:0]  err_count;
  logic [AW-1:0] fail_addr;
  logic [3:0]  fail_data;

  bist_seq_engine dut (
    .clk(clk), .TLR_n(TLR_n), .load_clear(load_clear), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .start(start), .abort(abort),
    .stop_on_err(stop_on_err), .loop_cnt(loop_cnt), .bist_out(bist_out),
    .bist_out_vld(bist_out_vld), .bist_in(bist_in), .busy(busy), .done(done),
    .fail(fail), .vec_count(vec_count), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int vld_cnt = 0;
  logic [3:0] sb [$];
  logic [3:0] corrupt [16];
  logic [3:0] h_stim [0:LAT];
  logic       h_vld  [0:LAT];

  function automatic logic [3:0] exp_f(input logic [3:0] s);
    return s ^ 4'hA;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample just after the edge, score issued vectors, drive response.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bist_out_vld === 1'b1) begin
      vld_cnt++;
      chk("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) chk("bist_out", bist_out, sb.pop_front());
    end
    for (int i = LAT; i > 0; i--) begin
      h_stim[i] = h_stim[i-1];
      h_vld[i]  = h_vld[i-1];
    end
    h_stim[0] = bist_out;
    h_vld[0]  = (bist_out_vld === 1'b1);
    bist_in = h_vld[LAT] ? (exp_f(h_stim[LAT]) ^ corrupt[h_stim[LAT]]) : 4'h0;
  endtask

  task automatic load_vec(input logic [3:0] s, input logic [3:0] m, input logic l);
    load_data  = {s, exp_f(s), m, l};
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wait_done(output int t);
    t = 0;
    while (done !== 1'b1 && t < 400) begin
      tick();
      t++;
    end
    chk("run_done", done, 1);
  endtask

  task automatic run_seq(input logic soe, input logic [7:0] lc, output int t);
    start = 1'b1; stop_on_err = soe; loop_cnt = lc;
    vld_cnt = 0;
    tick();
    start = 1'b0;
    wait_done(t);
  endtask

  int t;

  initial begin
    for (int i = 0; i < 16; i++) corrupt[i] = 4'h0;
    for (int i = 0; i <= LAT; i++) begin h_stim[i] = '0; h_vld[i] = 1'b0; end

    // Reset
    TLR_n = 1'b0;
    repeat (3) tick();
    TLR_n = 1'b1;
    chk("rst_vec_count", vec_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_vld", bist_out_vld, 0);
    chk("rst_err", err_count, 0);
    chk("rst_load_ready", load_ready, 1);

    // Clean run of 4 vectors
    for (int i = 0; i < 4; i++) load_vec(4'(i), 4'hF, 1'b0);
    chk("t1_vec_count", vec_count, 4);
    for (int i = 0; i < 4; i++) sb.push_back(4'(i));
    run_seq(1'b0, 8'd0, t);
    chk("t1_vld_cycles", vld_cnt, 4);
    chk("t1_done_tick", t, 4 + LAT);
    chk("t1_err", err_count, 0);
    chk("t1_fail", fail, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // Stop on error at vector 2, second pass cut short
    corrupt[2] = 4'h5;
    for (int i = 0; i < 5; i++) sb.push_back(4'(i % 4));
    run_seq(1'b1, 8'd1, t);
    chk("t2_vld_cycles", vld_cnt, 5);
    chk("t2_fail", fail, 1);
    chk("t2_busy", busy, 0);
    chk("t2_fail_addr", fail_addr, 2);
    chk("t2_fail_data", fail_data, exp_f(4'd2) ^ 4'h5);
    chk("t2_err", err_count, 1);
    repeat (5) tick();
    chk("t2_no_more_vld", vld_cnt, 5);
    chk("t2_err_held", err_count, 1);
    chk("t2_sb_empty", sb.size(), 0);

    // Count all errors over two passes
    corrupt[2] = 4'h0; corrupt[1] = 4'h3; corrupt[3] = 4'h8;
    for (int i = 0; i < 8; i++) sb.push_back(4'(i % 4));
    run_seq(1'b0, 8'd1, t);
    chk("t3_vld_cycles", vld_cnt, 8);
    chk("t3_done_tick", t, 8 + LAT);
    chk("t3_err", err_count, 4);
    chk("t3_fail_addr", fail_addr, 1);
    chk("t3_fail_data", fail_data, exp_f(4'd1) ^ 4'h3);
    chk("t3_fail", fail, 1);
    chk("t3_sb_empty", sb.size(), 0);

    // load_clear from DONE, last flag and masked-out corruption
    load_clear = 1'b1; tick(); load_clear = 1'b0;
    chk("t4_clear_count", vec_count, 0);
    chk("t4_clear_idle", done, 0);
    corrupt[3] = 4'h0;
    for (int i = 0; i < 6; i++) load_vec(4'(i), (i == 1) ? 4'h0 : 4'hF, i == 2);
    chk("t4_vec_count", vec_count, 6);
    for (int i = 0; i < 3; i++) sb.push_back(4'(i));
    run_seq(1'b1, 8'd0, t);
    chk("t4_vld_cycles", vld_cnt, 3);
    chk("t4_done_tick", t, 3 + LAT);
    chk("t4_err", err_count, 0);
    chk("t4_fail", fail, 0);

    // Abort mid-run
    for (int i = 0; i < 18; i++) sb.push_back(4'(i % 3));
    start = 1'b1; loop_cnt = 8'd5; stop_on_err = 1'b0;
    tick(); start = 1'b0;
    tick(); tick();
    chk("t5_busy_before", busy, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_vld", bist_out_vld, 0);
    chk("t5_abort_done", done, 0);
    chk("t5_abort_count", vec_count, 6);
    chk("t5_load_ready", load_ready, 1);
    sb.delete();
    repeat (3) tick();

    // Reset during DRAIN
    for (int i = 0; i < 3; i++) sb.push_back(4'(i));
    start = 1'b1; loop_cnt = 8'd0;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t6_in_drain_busy", busy, 1);
    chk("t6_in_drain_vld", bist_out_vld, 0);
    TLR_n = 1'b0; tick(); TLR_n = 1'b1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_vld", bist_out_vld, 0);
    chk("t6_rst_count", vec_count, 0);
    chk("t6_sb_empty", sb.size(), 0);
    repeat (3) tick();

    // Fill memory; start wins over a simultaneous load beat
    corrupt[1] = 4'h0;
    for (int i = 0; i < DEPTH-1; i++) load_vec(4'(i), 4'hF, 1'b0);
    chk("t7_vec_255", vec_count, DEPTH-1);
    load_data = {4'h7, exp_f(4'h7), 4'hF, 1'b0};
    load_valid = 1'b1; start = 1'b1; stop_on_err = 1'b0; loop_cnt = 8'd0;
    #1;
    chk("t7_ready_during_start", load_ready, 0);
    for (int i = 0; i < DEPTH-1; i++) sb.push_back(4'(i));
    vld_cnt = 0;
    tick();
    load_valid = 1'b0; start = 1'b0;
    chk("t7_no_write", vec_count, DEPTH-1);
    chk("t7_running", busy, 1);
    wait_done(t);
    chk("t7_vld_cycles", vld_cnt, DEPTH-1);
    chk("t7_err", err_count, 0);
    chk("t7_sb_empty", sb.size(), 0);
    abort = 1'b1; tick(); abort = 1'b0;
    load_vec(4'hF, 4'hF, 1'b0);
    chk("t7_full_count", vec_count, DEPTH);
    chk("t7_full_ready", load_ready, 0);
    load_vec(4'h3, 4'hF, 1'b0);
    chk("t7_no_wrap", vec_count, DEPTH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
